// File: rtl/cga_tty.sv
// Teletype writer for the 80x25 CGA text buffer: prints bytes as char/attr pairs,
// handles CR/LF/BS/FF, scrolls by copying video RAM and drives the scanout cursor.
module cga_tty #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 25,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_attr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [12:0] address,
  output logic [7:0]  wdata,
  output logic        we,
  input  logic [7:0]  rdata,
  output logic [10:0] cursor,
  output logic        busy
);

  localparam int unsigned AW           = 13;
  localparam int unsigned CNT_W        = 12;
  localparam int unsigned ROW_W        = 5;
  localparam int unsigned COL_W        = 7;
  localparam int unsigned CUR_W        = 11;
  localparam int unsigned ROW_BYTES    = 2 * COLS;
  localparam int unsigned SCR_BYTES    = ROW_BYTES * (ROWS - 1);
  localparam int unsigned SCREEN_BYTES = ROW_BYTES * ROWS;
  localparam logic [AW-1:0]    VBASE      = 13'h1000;
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
  localparam logic [7:0]       RESET_ATTR = 8'h07;
  localparam logic [7:0]       CH_BS      = 8'h08;
  localparam logic [7:0]       CH_LF      = 8'h0A;
  localparam logic [7:0]       CH_FF      = 8'h0C;
  localparam logic [7:0]       CH_CR      = 8'h0D;

  typedef enum logic [2:0] {
    IDLE, PUT_CH, PUT_AT, ADV, SCR_RD, SCR_WR, CLR_ROW, CLS
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [COL_W-1:0]  col, col_n;
  logic [7:0]        cur_attr, attr_n;
  logic [7:0]        ch, ch_n;
  logic [AW-1:0]     addr_n;
  logic [7:0]        wdata_q, wdata_n;
  logic              we_n;
  logic [CUR_W-1:0]  cursor_n;

  function automatic logic [CUR_W-1:0] cell_of(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
    return CUR_W'(CUR_W'(r) * CUR_W'(COLS) + CUR_W'(c));
  endfunction

  // The sync RAM returns the scroll source byte during the write cycle itself,
  // so the copy forwards rdata straight onto the write bus.
  assign wdata = (state == SCR_WR) ? rdata : wdata_q;

  // Next-state and next-output logic; registered outputs always describe the
  // state held in the state register.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    row_n    = row;
    col_n    = col;
    attr_n   = cur_attr;
    ch_n     = ch;
    addr_n   = address;
    wdata_n  = wdata_q;
    we_n     = 1'b0;
    cursor_n = cursor;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          ch_n   = in_data;
          attr_n = in_attr;
          case (in_data)
            CH_CR, CH_BS: state_n = ADV;
            CH_LF: begin
              if (row == LAST_ROW) begin
                state_n = SCR_RD;
                cnt_n   = '0;
                addr_n  = VBASE + AW'(ROW_BYTES);
              end else begin
                state_n = ADV;
              end
            end
            CH_FF: begin
              state_n = CLS;
              cnt_n   = '0;
              we_n    = 1'b1;
              addr_n  = VBASE;
              wdata_n = BLANK;
            end
            default: begin
              state_n = PUT_CH;
              we_n    = 1'b1;
              addr_n  = VBASE + AW'({cursor, 1'b0});
              wdata_n = in_data;
            end
          endcase
        end
      end
      PUT_CH: begin
        state_n = PUT_AT;
        we_n    = 1'b1;
        addr_n  = address + AW'(1);
        wdata_n = cur_attr;
      end
      PUT_AT: state_n = ADV;
      ADV: begin
        state_n = IDLE;
        case (ch)
          CH_CR: col_n = '0;
          CH_LF: row_n = row + ROW_W'(1);
          CH_BS: begin
            if (col != '0) begin
              col_n = col - COL_W'(1);
            end else if (row != '0) begin
              row_n = row - ROW_W'(1);
              col_n = LAST_COL;
            end
          end
          default: begin
            if (col == LAST_COL) begin
              col_n = '0;
              if (row == LAST_ROW) state_n = SCR_RD;
              else                 row_n = row + ROW_W'(1);
            end else begin
              col_n = col + COL_W'(1);
            end
          end
        endcase
        if (state_n == SCR_RD) begin
          cnt_n  = '0;
          addr_n = VBASE + AW'(ROW_BYTES);
        end else begin
          cursor_n = cell_of(row_n, col_n);
        end
      end
      SCR_RD: begin
        state_n = SCR_WR;
        we_n    = 1'b1;
        addr_n  = VBASE + AW'(cnt);
      end
      SCR_WR: begin
        if (cnt == CNT_W'(SCR_BYTES - 1)) begin
          state_n = CLR_ROW;
          cnt_n   = '0;
          we_n    = 1'b1;
          addr_n  = VBASE + AW'(SCR_BYTES);
          wdata_n = BLANK;
        end else begin
          state_n = SCR_RD;
          cnt_n   = cnt + CNT_W'(1);
          addr_n  = VBASE + AW'(ROW_BYTES) + AW'(cnt_n);
        end
      end
      CLR_ROW: begin
        if (cnt == CNT_W'(ROW_BYTES - 1)) begin
          state_n  = IDLE;
          row_n    = LAST_ROW;
          cursor_n = cell_of(LAST_ROW, col);
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          we_n    = 1'b1;
          addr_n  = address + AW'(1);
          wdata_n = addr_n[0] ? cur_attr : BLANK;
        end
      end
      CLS: begin
        // cnt leaves reset all-ones so the first increment lands on byte 0
        if (cnt == CNT_W'(SCREEN_BYTES - 1)) begin
          state_n  = IDLE;
          row_n    = '0;
          col_n    = '0;
          cursor_n = '0;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          we_n    = 1'b1;
          addr_n  = VBASE + AW'(cnt_n);
          wdata_n = addr_n[0] ? cur_attr : BLANK;
        end
      end
    endcase
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      state    <= CLS;
      cnt      <= '1;
      row      <= '0;
      col      <= '0;
      cur_attr <= RESET_ATTR;
      ch       <= '0;
      address  <= '0;
      wdata_q  <= '0;
      we       <= 1'b0;
      cursor   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      row      <= row_n;
      col      <= col_n;
      cur_attr <= attr_n;
      ch       <= ch_n;
      address  <= addr_n;
      wdata_q  <= wdata_n;
      we       <= we_n;
      cursor   <= cursor_n;
      in_ready <= (state_n == IDLE);
      busy     <= (state_n != IDLE);
    end
  end

endmodule

// File: doc/cga_tty.md
Name: cga_tty

Overview:
- Teletype-style writer for the 80x25 text video memory that the CGA scanout reads.
- Accepts a stream of bytes over a valid/ready handshake.
- Writes character/attribute pairs into video RAM at 0x1000 + 2*cell, where the character is at the even address and the attribute at the odd address.
- Interprets CR, LF, BS and FF; scrolls by copying memory; drives the 11-bit cursor position consumed by the scanout.

Parameters:
COLS, 80, characters per row
ROWS, 25, rows per screen
BLANK, 8'h20, fill character for clear and scroll

Ports:
clock_25  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_data  in  8  byte to print or control code
in_attr  in  8  attribute for this byte, sampled on accept
in_valid  in  1  in_data/in_attr valid
in_ready  out  1  block can accept a byte this cycle
address  out  13  video RAM address; 0x1000..0x1F9F used
wdata  out  8  write data
we  out  1  write strobe, one byte per cycle
rdata  in  8  read data; valid the cycle after address is presented (sync RAM)
cursor  out  11  cursor cell index 0..1999 (row*80+col)
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset is asynchronous. All outputs are registered.
- Reset values: address=0, wdata=0, we=0, cursor=0, in_ready=0, busy=1; internal row=0, col=0, cur_attr=8'h07.
- Leaving reset, the block enters CLS.
- Handshake:
  - in_ready = (state==IDLE).
  - A byte is accepted on a rising edge where in_valid && in_ready; in_attr is latched into cur_attr on that edge.
  - Exactly one byte is accepted per handshake; in_ready drops the cycle after accept.
- States: IDLE, PUT_CH, PUT_AT, ADV, SCR_RD, SCR_WR, CLR_ROW, CLS.
- Printable byte: any value other than 0x08, 0x0A, 0x0C, 0x0D.
  - Accept at edge N.
  - Cycle N+1 (PUT_CH): we=1, address=0x1000+2*cursor, wdata=byte.
  - Cycle N+2 (PUT_AT): we=1, address+1, wdata=cur_attr.
  - Cycle N+3 (ADV): col++. If col was 79: col=0, row++. If row was 24 as well: go to SCR_RD instead of incrementing the row.
  - in_ready=1 at N+4 when no scroll occurs.
- CR 0x0D: col=0, no write; return to IDLE via ADV. in_ready returns 2 cycles after accept.
- LF 0x0A: row++, col unchanged. At row 24, scroll instead; after the scroll, col is unchanged.
- BS 0x08: if cursor>0, cursor-1, wrapping col 0 to col 79 of the previous row. At cursor 0, no-op. No erase.
- FF 0x0C: enter CLS; afterwards row=col=0.
- CLS:
  - 4000 consecutive write cycles over addresses 0x1000..0x1F9F ascending.
  - Even addresses get BLANK; odd addresses get cur_attr (8'h07 after reset).
  - Then cursor=0, IDLE.
- Scroll:
  - For k=0..3839: SCR_RD presents address 0x1000+160+k with we=0. The next cycle, SCR_WR writes rdata to 0x1000+k with we=1. That is 2 cycles per byte.
  - Then CLR_ROW: 160 writes to 0x1000+3840..0x1F9F, BLANK/cur_attr alternating.
  - Then row=24, IDLE.
  - Total scroll cost is 7840 cycles.
- cursor = row*COLS+col, updated registered at the end of each command (ADV/scroll/CLS completion). It never exceeds 1999.
- we is low in IDLE and SCR_RD. address holds its last value when we=0 in IDLE.
- in_valid while busy is ignored, so no data is lost; the source must hold it.
- Reset asserted mid-operation: immediate return to reset values, then a fresh CLS. A partially completed scroll is not resumed.

Test Plan:
- Reset: release reset -> in_ready=0 for 4000 cycles, with 4000 writes alternating 0x20/0x07 at 0x1000..0x1F9F. Then in_ready=1 and cursor=0.
- Print: in_data=0x41, in_attr=0x1E at cursor 0 -> write 0x41@0x1000 then 0x1E@0x1001 on consecutive cycles; cursor=1; in_ready back 4 cycles after accept.
- Wrap: 80 printable bytes from cursor 0 -> last char written at 0x109E; cursor=80.
- CR/LF/BS: CR then LF from cursor 85 -> cursor=80, then cursor=160. BS at cursor 0 -> cursor stays 0 with no write.
- Scroll: with a memory model filled with a pattern, LF at cursor 1990 ->
  - cell 0 holds the old cell 80;
  - cells 1920..1999 hold 0x20/cur_attr;
  - cursor=1990;
  - exactly 7840 busy cycles.
- FF, then reset mid-scroll:
  - FF at cursor 500 -> full clear, cursor=0.
  - Asserting reset during a scroll -> outputs zero immediately, then CLS runs.
